// File: rtl/alu_seq_pkg.sv
// -----------------------------------------------------------------------------
// alu_seq_pkg
// Shared definitions for alu_wide_sequencer:
//   op_e        - 4-bit request operation codes
//   state_e     - sequencer FSM states (IDLE -> LO -> HI -> DONE)
//   SEL_*       - 16-bit ALU select encodings for each operation
//   ALU_MODE_*  - ALU mode drive (0 = arithmetic, 1 = logic)
//   op_is_arith - helper: ops whose high pass consumes the low-pass carry
// -----------------------------------------------------------------------------
package alu_seq_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_ADC  = 4'd2,
        OP_SBB  = 4'd3,
        OP_AND  = 4'd4,
        OP_OR   = 4'd5,
        OP_XOR  = 4'd6,
        OP_NOTA = 4'd7,
        OP_SHL  = 4'd8,
        OP_SHR  = 4'd9
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Arithmetic-mode selects
    localparam logic [3:0] SEL_ADD  = 4'b0000;
    localparam logic [3:0] SEL_SUB  = 4'b0001;
    localparam logic [3:0] SEL_ADC  = 4'b0010;
    localparam logic [3:0] SEL_SBB  = 4'b0011;
    // Logic-mode selects
    localparam logic [3:0] SEL_AND  = 4'b0000;
    localparam logic [3:0] SEL_OR   = 4'b0001;
    localparam logic [3:0] SEL_XOR  = 4'b0010;
    localparam logic [3:0] SEL_NOTA = 4'b0011;
    localparam logic [3:0] SEL_SHL  = 4'b0111;
    localparam logic [3:0] SEL_SHR  = 4'b1000;

    localparam logic ALU_MODE_ARITH = 1'b0;
    localparam logic ALU_MODE_LOGIC = 1'b1;

    function automatic logic op_is_arith(input logic [3:0] op);
        return (op <= 4'd3);
    endfunction

endpackage

// File: rtl/alu_wide_sequencer.sv
// -----------------------------------------------------------------------------
// alu_wide_sequencer
// Issue stage that runs one 2*ALU_W-bit operation as two passes through an
// external ALU_W-bit ALU (low half then high half; SHR runs high half first).
// Arithmetic carry/borrow from the first pass is chained into the second.
//
// Configuration macro: ALU_WIDE_SEQ_SHIFT_EN
//   defined   - ops 8 (SHL) and 9 (SHR) are legal
//   undefined - ops 8 and 9 are reported illegal
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake
//   req_op, req_a, req_b       operation and 2*ALU_W-bit operands
//   req_carry                  carry/borrow in for ADC/SBB
//   rsp_valid/rsp_ready        response handshake
//   rsp_result                 assembled 2*ALU_W-bit result
//   rsp_carry                  high-half carry/borrow or shifted-out bit
//   rsp_zero, rsp_neg          result == 0, result MSB
//   rsp_illegal                op undefined in this build
//   alu_in_a, alu_in_b         ALU operand drives (registered)
//   alu_select, alu_mode       ALU function drives (registered)
//   alu_carry_in               ALU carry-in drive (registered)
//   alu_out, alu_carry_out     ALU results, sampled in LO/HI
//   dbg_state                  current FSM state
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both 1. A request is accepted only in IDLE; a response is held stable
// in DONE until rsp_ready is seen, then the FSM spends one cycle returning
// to IDLE, so a retire and an accept never share a cycle.
// -----------------------------------------------------------------------------
module alu_wide_sequencer
    import alu_seq_pkg::*;
#(
    parameter int ALU_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [3:0]           req_op,
    input  logic [2*ALU_W-1:0]   req_a,
    input  logic [2*ALU_W-1:0]   req_b,
    input  logic                 req_carry,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [2*ALU_W-1:0]   rsp_result,
    output logic                 rsp_carry,
    output logic                 rsp_zero,
    output logic                 rsp_neg,
    output logic                 rsp_illegal,
    output logic [ALU_W-1:0]     alu_in_a,
    output logic [ALU_W-1:0]     alu_in_b,
    output logic [3:0]           alu_select,
    output logic                 alu_mode,
    output logic                 alu_carry_in,
    input  logic [ALU_W-1:0]     alu_out,
    input  logic                 alu_carry_out,
    output logic [1:0]           dbg_state
);

    localparam int RW = 2 * ALU_W;

    state_e          state, next_state;
    logic            accept;

    logic [3:0]      op_q;
    logic [RW-1:0]   a_q, b_q;
    logic            c_q;
    logic [RW-1:0]   result_q;
    logic            carry_q;
    logic            illegal_q;

    // Next-cycle ALU drive values, registered into alu_*
    logic [3:0]      src_op;
    logic [RW-1:0]   src_a, src_b;
    logic            src_c;
    logic            first_pass, second_pass, hi_half;
    logic [ALU_W-1:0] drv_a, drv_b;
    logic [3:0]      drv_sel;
    logic            drv_mode, drv_cin;

    function automatic logic op_legal(input logic [3:0] op);
`ifdef ALU_WIDE_SEQ_SHIFT_EN
        return (op <= 4'd9);
`else
        return (op <= 4'd7);
`endif
    endfunction

    assign accept    = req_valid && req_ready;
    assign dbg_state = state;

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (accept) next_state = op_legal(req_op) ? ST_LO : ST_DONE;
            ST_LO:   next_state = ST_HI;
            ST_HI:   next_state = ST_DONE;
            ST_DONE: if (rsp_ready) next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        req_ready   = (state == ST_IDLE);
        rsp_valid   = (state == ST_DONE);
        rsp_result  = result_q;
        rsp_carry   = carry_q;
        rsp_illegal = illegal_q;
        rsp_neg     = result_q[RW-1];
        // Qualified so the flag is 0 out of reset even though result_q is 0.
        rsp_zero    = (state == ST_DONE) && (result_q == '0);
    end

    // ---------------- ALU drive computation ----------------
    // Drives are computed for the state being entered so they are stable
    // registers for the whole LO/HI cycle. On the accept edge the operands
    // are not yet latched, so the request inputs feed the first pass.
    always_comb begin
        src_op      = (state == ST_IDLE) ? req_op    : op_q;
        src_a       = (state == ST_IDLE) ? req_a     : a_q;
        src_b       = (state == ST_IDLE) ? req_b     : b_q;
        src_c       = (state == ST_IDLE) ? req_carry : c_q;
        first_pass  = (next_state == ST_LO);
        second_pass = (next_state == ST_HI);
        hi_half     = second_pass;
`ifdef ALU_WIDE_SEQ_SHIFT_EN
        // SHR walks from the top half down so the high bit-0 is known
        // before the low pass needs it.
        if (src_op == OP_SHR) hi_half = first_pass;
`endif
        drv_a    = '0;
        drv_b    = '0;
        drv_sel  = '0;
        drv_mode = ALU_MODE_ARITH;
        drv_cin  = 1'b0;
        if (first_pass || second_pass) begin
            drv_a = hi_half ? src_a[RW-1:ALU_W] : src_a[ALU_W-1:0];
            drv_b = hi_half ? src_b[RW-1:ALU_W] : src_b[ALU_W-1:0];
            // Entering HI means the ALU is currently showing the low pass,
            // so alu_carry_out is the chain bit; registering it into
            // alu_carry_in is the chain storage.
            case (src_op)
                OP_ADD: begin
                    drv_sel = second_pass ? SEL_ADC : SEL_ADD;
                    drv_cin = second_pass & alu_carry_out;
                end
                OP_SUB: begin
                    drv_sel = second_pass ? SEL_SBB : SEL_SUB;
                    drv_cin = second_pass & alu_carry_out;
                end
                OP_ADC: begin
                    drv_sel = SEL_ADC;
                    drv_cin = second_pass ? alu_carry_out : src_c;
                end
                OP_SBB: begin
                    drv_sel = SEL_SBB;
                    drv_cin = second_pass ? alu_carry_out : src_c;
                end
                OP_AND:  begin drv_mode = ALU_MODE_LOGIC; drv_sel = SEL_AND;  end
                OP_OR:   begin drv_mode = ALU_MODE_LOGIC; drv_sel = SEL_OR;   end
                OP_XOR:  begin drv_mode = ALU_MODE_LOGIC; drv_sel = SEL_XOR;  end
                OP_NOTA: begin drv_mode = ALU_MODE_LOGIC; drv_sel = SEL_NOTA; end
`ifdef ALU_WIDE_SEQ_SHIFT_EN
                OP_SHL:  begin drv_mode = ALU_MODE_LOGIC; drv_sel = SEL_SHL;  end
                OP_SHR:  begin drv_mode = ALU_MODE_LOGIC; drv_sel = SEL_SHR;  end
`endif
                default: begin end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_in_a     <= '0;
            alu_in_b     <= '0;
            alu_select   <= '0;
            alu_mode     <= 1'b0;
            alu_carry_in <= 1'b0;
        end else begin
            alu_in_a     <= drv_a;
            alu_in_b     <= drv_b;
            alu_select   <= drv_sel;
            alu_mode     <= drv_mode;
            alu_carry_in <= drv_cin;
        end
    end

    // ---------------- operand / result registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= 1'b0;
            result_q  <= '0;
            carry_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else if (accept) begin
            op_q      <= req_op;
            a_q       <= req_a;
            b_q       <= req_b;
            c_q       <= req_carry;
            result_q  <= '0;
            carry_q   <= 1'b0;
            illegal_q <= !op_legal(req_op);
        end else if (state == ST_LO) begin
`ifdef ALU_WIDE_SEQ_SHIFT_EN
            if (op_q == OP_SHR) result_q[RW-1:ALU_W] <= alu_out;
            else                result_q[ALU_W-1:0]  <= alu_out;
`else
            result_q[ALU_W-1:0] <= alu_out;
`endif
        end else if (state == ST_HI) begin
            case (op_q)
`ifdef ALU_WIDE_SEQ_SHIFT_EN
                OP_SHL: begin
                    // Bit crossing the half boundary is inserted here.
                    result_q[RW-1:ALU_W] <= alu_out | {{(ALU_W-1){1'b0}}, a_q[ALU_W-1]};
                    carry_q              <= a_q[RW-1];
                end
                OP_SHR: begin
                    result_q[ALU_W-1:0]  <= alu_out | {a_q[ALU_W], {(ALU_W-1){1'b0}}};
                    carry_q              <= a_q[0];
                end
`endif
                default: begin
                    result_q[RW-1:ALU_W] <= alu_out;
                    carry_q              <= op_is_arith(op_q) ? alu_carry_out : 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_wide_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_wide_sequencer
// Directed plus randomized checks of alu_wide_sequencer. A behavioural
// 16-bit ALU sits beside the DUT; expected responses come from a 32-bit
// arithmetic reference model pushed into a scoreboard queue.
// -----------------------------------------------------------------------------
module tb_alu_wide_sequencer;
    import alu_seq_pkg::*;

    localparam int W  = 16;
    localparam int RW = 32;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [3:0]    req_op;
    logic [RW-1:0] req_a, req_b;
    logic          req_carry;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [RW-1:0] rsp_result;
    logic          rsp_carry, rsp_zero, rsp_neg, rsp_illegal;
    logic [W-1:0]  alu_in_a, alu_in_b, alu_out;
    logic [3:0]    alu_select;
    logic          alu_mode, alu_carry_in, alu_carry_out;
    logic [1:0]    dbg_state;

    int tests_run = 0;
    int fails     = 0;

    // {illegal, neg, zero, carry, result}
    logic [35:0] exp_q[$];

    // Drives captured during the two passes, indexed by cycle after accept
    logic [3:0] rec_sel [0:3];
    logic       rec_mode[0:3];
    logic       rec_cin [0:3];
    int         lat;

    alu_wide_sequencer #(.ALU_W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_carry(req_carry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .rsp_neg(rsp_neg),
        .rsp_illegal(rsp_illegal),
        .alu_in_a(alu_in_a), .alu_in_b(alu_in_b), .alu_select(alu_select),
        .alu_mode(alu_mode), .alu_carry_in(alu_carry_in),
        .alu_out(alu_out), .alu_carry_out(alu_carry_out),
        .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- behavioural 16-bit ALU ----------------
    logic [W:0] alu_res;
    always_comb begin
        alu_res = '0;
        if (alu_mode == 1'b0) begin
            case (alu_select)
                4'b0000: alu_res = {1'b0, alu_in_a} + {1'b0, alu_in_b};
                4'b0001: alu_res = {1'b0, alu_in_a} - {1'b0, alu_in_b};
                4'b0010: alu_res = {1'b0, alu_in_a} + {1'b0, alu_in_b} + {16'd0, alu_carry_in};
                4'b0011: alu_res = {1'b0, alu_in_a} - {1'b0, alu_in_b} - {16'd0, alu_carry_in};
                default: alu_res = '0;
            endcase
        end else begin
            case (alu_select)
                4'b0000: alu_res = {1'b0, alu_in_a & alu_in_b};
                4'b0001: alu_res = {1'b0, alu_in_a | alu_in_b};
                4'b0010: alu_res = {1'b0, alu_in_a ^ alu_in_b};
                4'b0011: alu_res = {1'b0, ~alu_in_a};
                4'b0111: alu_res = {alu_in_a[W-1], alu_in_a[W-2:0], 1'b0};
                4'b1000: alu_res = {alu_in_a[0], 1'b0, alu_in_a[W-1:1]};
                default: alu_res = '0;
            endcase
        end
    end
    assign alu_out       = alu_res[W-1:0];
    assign alu_carry_out = alu_res[W];

    // ---------------- reference model (32-bit view) ----------------
    function automatic logic [35:0] ref_model(input logic [3:0] op, input logic [RW-1:0] a,
                                              input logic [RW-1:0] b, input logic c);
        logic [RW:0] t;
        logic        ill;
        t   = '0;
        ill = 1'b0;
        case (op)
            4'd0: t = {1'b0, a} + {1'b0, b};
            4'd1: t = {1'b0, a} - {1'b0, b};
            4'd2: t = {1'b0, a} + {1'b0, b} + {32'd0, c};
            4'd3: t = {1'b0, a} - {1'b0, b} - {32'd0, c};
            4'd4: t = {1'b0, a & b};
            4'd5: t = {1'b0, a | b};
            4'd6: t = {1'b0, a ^ b};
            4'd7: t = {1'b0, ~a};
`ifdef ALU_WIDE_SEQ_SHIFT_EN
            4'd8: t = {a[31], a[30:0], 1'b0};
            4'd9: t = {a[0], 1'b0, a[31:1]};
`endif
            default: ill = 1'b1;
        endcase
        return {ill, t[31], (t[31:0] == 32'd0), t[32], t[31:0]};
    endfunction

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [35:0] rsp_vec();
        return {rsp_illegal, rsp_neg, rsp_zero, rsp_carry, rsp_result};
    endfunction

    // ---------------- driver ----------------
    // Issues one request, checks latency, response, held response and retire.
    task automatic run_op(input logic [3:0] op, input logic [RW-1:0] a, input logic [RW-1:0] b,
                          input logic c, input int hold);
        logic [35:0] exp;
        exp = ref_model(op, a, b, c);
        exp_q.push_back(exp);
        for (int i = 0; i < 4; i++) begin
            rec_sel[i] = '0; rec_mode[i] = 1'b0; rec_cin[i] = 1'b0;
        end
        @(negedge clk);
        check("req_ready_idle", 36'(req_ready), 36'd1);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_carry = c;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        while (!rsp_valid && lat < 10) begin
            if (lat < 4) begin
                rec_sel[lat] = alu_select; rec_mode[lat] = alu_mode; rec_cin[lat] = alu_carry_in;
            end
            // Junk requests while busy must be ignored.
            req_valid = 1'b1;
            req_op = 4'($urandom_range(0, 15)); req_a = $urandom; req_b = $urandom;
            req_carry = 1'($urandom_range(0, 1));
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        req_valid = 1'b0;
        check("latency", 36'(lat), exp[35] ? 36'd1 : 36'd3);
        check("rsp_fields", rsp_vec(), exp_q.pop_front());
        check("idle_drive_done", {15'd0, alu_in_a, alu_in_b, alu_select, alu_mode, alu_carry_in}, 36'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_ctrl", {34'd0, rsp_valid, req_ready}, 36'b10);
            check("hold_data", rsp_vec(), exp);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check("retire", {34'd0, rsp_valid, req_ready}, 36'b01);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0]    r_op;
        logic [RW-1:0] r_a, r_b;
        rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0;
        req_carry = 1'b0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_req_ready", 36'(req_ready), 36'd1);
        check("reset_outputs", {rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_neg},
              36'd0);
        check("reset_alu_drive", {13'd0, rsp_illegal, alu_in_a, alu_in_b, alu_select,
              alu_mode, alu_carry_in, dbg_state}, 36'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // ADD with carry across the half boundary
        run_op(4'd0, 32'h0001_FFFF, 32'h0000_0001, 1'b0, 0);
        check("add_lo_drive", {27'd0, rec_sel[1], rec_mode[1], rec_cin[1], 3'd0}, 36'd0);
        check("add_hi_drive", {30'd0, rec_sel[2], rec_mode[2], rec_cin[2]}, {30'd0, 4'b0010, 1'b0, 1'b1});

        // SUB with borrow chain
        run_op(4'd1, 32'h0000_0000, 32'h0000_0001, 1'b0, 0);
        check("sub_hi_drive", {30'd0, rec_sel[2], rec_mode[2], rec_cin[2]}, {30'd0, 4'b0011, 1'b0, 1'b1});

        // ADC with carry in wraps to zero
        run_op(4'd2, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 0);
        check("adc_lo_cin", 36'(rec_cin[1]), 36'd1);

        // XOR of equal operands, logic mode on both passes
        run_op(4'd6, 32'h1234_5678, 32'h1234_5678, 1'b0, 0);
        check("xor_modes", {32'd0, rec_mode[1], rec_mode[2], 2'b00}, 36'b1100);

        // Response held with rsp_ready low
        run_op(4'd3, 32'h8000_0000, 32'h0000_0001, 1'b1, 5);

        // Reset pulsed during HI
        @(negedge clk);
        req_valid = 1'b1; req_op = 4'd0; req_a = 32'h1111_1111; req_b = 32'h2222_2222;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid_reset_in_hi", 36'(dbg_state), 36'd2);
        rst_n = 1'b0;
        #1;
        check("mid_reset_rsp_valid", {34'd0, rsp_valid, req_ready}, 36'b01);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_reset_quiet", {34'd0, rsp_valid, req_ready}, 36'b01);
        end

`ifdef ALU_WIDE_SEQ_SHIFT_EN
        run_op(4'd8, 32'h8000_8000, 32'h0, 1'b0, 0);
        run_op(4'd9, 32'h0001_0001, 32'h0, 1'b0, 0);
`else
        run_op(4'd8, 32'h8000_8000, 32'h0, 1'b0, 0);
        run_op(4'd9, 32'h0001_0001, 32'h0, 1'b0, 0);
`endif
        run_op(4'd15, 32'hDEAD_BEEF, 32'h1, 1'b1, 2);

        // Randomized operations
        for (int n = 0; n < 40; n++) begin
            r_op = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0:       r_a = 32'hFFFF_FFFF;
                1:       r_a = 32'h0000_FFFF;
                default: r_a = $urandom;
            endcase
            case ($urandom_range(0, 3))
                0:       r_b = 32'h0000_0001;
                1:       r_b = r_a;
                default: r_b = $urandom;
            endcase
            run_op(r_op, r_a, r_b, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
        end

        check("scoreboard_empty", 36'(exp_q.size()), 36'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/alu_wide_sequencer.md
# alu_wide_sequencer

Upstream issue stage for the 16-bit ALU. It accepts 32-bit operation requests over a valid/ready handshake and splits each into two ALU passes: low half, then high half. For arithmetic ops the low-half carry/borrow is chained into the high half. It assembles a 32-bit result plus flags and presents it on a valid/ready response port. The 16-bit ALU is instantiated beside it in the parent; this block drives all ALU inputs and samples `alu_out` and `alu_carry_out` combinationally.

## Interface
- `ALU_W`, 16, ALU datapath width; must equal the ALU's width. Request/response width is 2*`ALU_W`.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request.
- `req_op` in 4: operation code (see Operation).
- `req_a`, `req_b` in 2*ALU_W: operands.
- `req_carry` in 1: carry/borrow in for ADC/SBB.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_result` out 2*ALU_W: assembled result.
- `rsp_carry` out 1: high-half carry/borrow, or shifted-out bit.
- `rsp_zero` out 1: `rsp_result` == 0.
- `rsp_neg` out 1: `rsp_result` MSB.
- `rsp_illegal` out 1: op undefined in this build.
- `alu_in_a`, `alu_in_b` out ALU_W: ALU operand drive.
- `alu_select` out 4: ALU select drive.
- `alu_mode` out 1: ALU mode drive; 0 = arithmetic, 1 = logic.
- `alu_carry_in` out 1: ALU carry-in drive.
- `alu_out` in ALU_W: ALU result.
- `alu_carry_out` in 1: ALU carry/borrow out.
- The ALU's compare output is left unconnected; the zero flag is computed locally.

## Operation
- **Op codes.** Each entry gives the low-pass select / high-pass select.
  - 0 ADD: arithmetic, select 0000 / 0010 (high pass uses carry_in = low carry).
  - 1 SUB: arithmetic, select 0001 / 0011 (high pass uses carry_in = low borrow).
  - 2 ADC: arithmetic, select 0010 with carry_in = `req_carry` / 0010 with carry_in = low carry.
  - 3 SBB: arithmetic, select 0011 with carry_in = `req_carry` / 0011 with carry_in = low borrow.
  - 4 AND: logic, select 0000 on both passes.
  - 5 OR: logic, select 0001 on both passes.
  - 6 XOR: logic, select 0010 on both passes.
  - 7 NOTA: logic, select 0011 on both passes.
  - 8 SHL and 9 SHR: macro-dependent (see Configuration).
  - Any other op: illegal.
- **FSM.** States IDLE → LO → HI → DONE → IDLE.
  - IDLE: `req_ready`=1. `req_valid`&&`req_ready` latches op/operands/carry and moves to LO.
  - LO: drives low halves; at the clock edge, captures `alu_out` into result[15:0] and `alu_carry_out` into the chain bit.
  - HI: drives high halves; captures into result[31:16] and `rsp_carry`.
  - DONE: `rsp_valid`=1. `rsp_ready` returns to IDLE.
- **Illegal op.** Skips LO and HI and goes straight to DONE with result 0, carry 0, zero 1, illegal 1. ALU drives stay idle.
- **Flags.**
  - Logic ops: `rsp_carry`=0.
  - SUB/SBB: carry = borrow, i.e. `alu_carry_out` = 1 when the 17-bit subtract wraps.
  - `rsp_zero` and `rsp_neg` are derived from the registered result.
- **Idle drive.** Outside LO/HI, all `alu_*` outputs are 0.
- **Request gating.** Request inputs are ignored while `req_ready`=0.
- **Response hold.** All `rsp_*` outputs stay stable while `rsp_valid`&&!`rsp_ready`.

## Timing
- Reset value of every output is 0, except `req_ready`=1. FSM resets to IDLE.
- Latency:
  - Legal op: `rsp_valid` rises 3 cycles after the accept edge.
  - Illegal op: `rsp_valid` rises 1 cycle after the accept edge.
- Throughput is at most one op per 4 cycles. DONE→IDLE costs one cycle, and a new request is never accepted in the same cycle a response retires.
- The ALU path is combinational within LO and HI: `alu_*` drives are registered outputs of the FSM, and results are captured at the end of the same cycle.
- Reset asserted mid-operation (LO/HI/DONE): in-flight op is discarded, `rsp_valid` drops immediately, FSM returns to IDLE. No response is ever produced for that op.

## Configuration
- Macro `ALU_WIDE_SEQ_SHIFT_EN`.
- Defined: ops 8 and 9 are legal.
  - SHL uses logic select 0111. Low pass result = a_lo<<1. High pass result = (a_hi<<1) | a_lo[15], with the bit inserted by the sequencer. `rsp_carry` = a[31].
  - SHR uses select 1000. High pass runs first, giving a_hi>>1. Low pass gives (a_lo>>1) | (a_hi[0]<<15). `rsp_carry` = a[0].
  - Latency is unchanged.
- Undefined: ops 8 and 9 are illegal.

## Structure
- Package `alu_seq_pkg` holds:
  - The 4-bit op enum.
  - The FSM state enum.
  - ALU select constants: ADD, SUB, ADC, SBB, AND, OR, XOR, NOTA, SHL, SHR.
  - `ALU_MODE_ARITH` and `ALU_MODE_LOGIC`.
- No sub-module: the FSM, the op decode and the result register stay in one module. The ALU is instantiated by the parent.

## Test plan
- ADD 0x0001FFFF + 0x00000001 → result 0x00020000, carry 0, zero 0; `rsp_valid` exactly 3 cycles after accept.
- SUB 0x00000000 - 0x00000001 → 0xFFFFFFFF, carry (borrow) 1, neg 1; high pass shows select 0011, `alu_carry_in` 1.
- ADC 0xFFFFFFFF + 0 with `req_carry`=1 → 0x00000000, carry 1, zero 1.
- XOR a=b=0x12345678 → 0, zero 1, carry 0; `alu_mode`=1 in both passes.
- `rsp_ready` low for 5 cycles → response held stable and `req_ready` 0 throughout. Separately, `rst_n` pulsed during HI → `rsp_valid` never rises; `req_ready` is 1 after release.
- With macro: SHL 0x80008000 → 0x00010000, carry 1; SHR 0x00010001 → 0x00008000, carry 1. Without macro: op 8 → `rsp_illegal` 1, result 0, latency 1.
